// File: rtl/matmul_sequencer_if.sv
// Operand/result handshake bundle between the matmul sequencer (master)
// and an inner-product unit (slave).
interface matmul_sequencer_if #(
    parameter int N = 4
);
    logic [32*N-1:0] row;
    logic [32*N-1:0] column;
    logic            row_o_stb;
    logic            column_o_stb;
    logic            row_o_ack;
    logic            column_o_ack;
    logic [31:0]     result;
    logic            result_i_stb;
    logic            result_i_ack;

    modport master (
        output row, column, row_o_stb, column_o_stb, result_i_ack,
        input  row_o_ack, column_o_ack, result, result_i_stb
    );

    modport slave (
        input  row, column, row_o_stb, column_o_stb, result_i_ack,
        output row_o_ack, column_o_ack, result, result_i_stb
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences C = A x B element by element through an external inner-product unit.
// Optional result-wait timeout: define MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer #(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [32*N*N-1:0]   matrix_a,
    input  logic [32*N*N-1:0]   matrix_b,
    matmul_sequencer_if.master  bus,
    output logic [32*N*N-1:0]   matrix_c,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND     = 3'd1;
    localparam logic [2:0] WAIT_RES = 3'd2;
    localparam logic [2:0] NEXT     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (N < 2 || N > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("matmul_sequencer: N must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    logic [2:0]          state;
    logic [32*N*N-1:0]   a_q;
    logic [32*N*N-1:0]   b_q;
    logic [IW-1:0]       r_q;
    logic [IW-1:0]       c_q;
    logic                row_stb;
    logic                col_stb;
    logic [32*N-1:0]     row_vec;
    logic [32*N-1:0]     col_vec;
    logic                acks_done;

    // Operand vectors come straight from the latched copies, so they stay
    // stable for the whole element without extra holding registers.
    always_comb begin
        row_vec = '0;
        col_vec = '0;
        for (int unsigned k = 0; k < N; k++) begin
            row_vec[32*k +: 32] = a_q[32*(int'(r_q)*N + int'(k)) +: 32];
            col_vec[32*k +: 32] = b_q[32*(int'(k)*N + int'(c_q)) +: 32];
        end
    end

    // A strobe already dropped means its ack was seen in an earlier cycle.
    assign acks_done = (!row_stb || bus.row_o_ack) && (!col_stb || bus.column_o_ack);

    assign bus.row          = row_vec;
    assign bus.column       = col_vec;
    assign bus.row_o_stb    = row_stb;
    assign bus.column_o_stb = col_stb;
    assign bus.result_i_ack = (state == SEND) || (state == WAIT_RES);

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            row_stb  <= 1'b0;
            col_stb  <= 1'b0;
            matrix_c <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= matrix_a;
                        b_q      <= matrix_b;
                        r_q      <= '0;
                        c_q      <= '0;
                        matrix_c <= '0;
                        busy     <= 1'b1;
                        row_stb  <= 1'b1;
                        col_stb  <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (row_stb && bus.row_o_ack)    row_stb <= 1'b0;
                    if (col_stb && bus.column_o_ack) col_stb <= 1'b0;
                    if (acks_done)                   state   <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (bus.result_i_stb) begin
                        matrix_c[32*(int'(r_q)*N + int'(c_q)) +: 32] <= bus.result;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (c_q == LAST && r_q == LAST) begin
                        r_q   <= '0;
                        c_q   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (c_q == LAST) begin
                            c_q <= '0;
                            r_q <= r_q + 1'b1;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                        row_stb <= 1'b1;
                        col_stb <= 1'b1;
                        state   <= SEND;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef MATMUL_SEQ_TIMEOUT_EN
            // Timeout overrides whatever the case statement scheduled.
            if (state == IDLE && start) begin
                tmo_cnt <= '0;
                err_q   <= 1'b0;
            end else if (state == SEND || state == WAIT_RES) begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt <= '0;
                    err_q   <= 1'b1;
                    row_stb <= 1'b0;
                    col_stb <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (N=2) with a behavioural inner-product responder.
module tb_matmul_sequencer;
    localparam int N = 2;
    localparam int W = 32*N*N;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        int unsigned  ra;
        int unsigned  ca;
        int unsigned  rd;
        bit           junk;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] matrix_a = '0;
    logic [W-1:0] matrix_b = '0;
    logic [W-1:0] matrix_c;
    logic         busy, done, error;

    matmul_sequencer_if #(.N(N)) bus ();

    matmul_sequencer #(.N(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .matrix_a(matrix_a), .matrix_b(matrix_b), .bus(bus),
        .matrix_c(matrix_c), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack4(input int unsigned w0, w1, w2, w3);
        return {32'(w3), 32'(w2), 32'(w1), 32'(w0)};
    endfunction

    // Responder configuration (written by main) and state (written by responder only)
    int unsigned ra = 0, ca = 0, rd = 0;
    bit          junk = 1'b0;
    bit          rsp_en = 1'b0;
    int          viol = 0;
    int          rs_txn = 0;
    int unsigned rs_t = 0;
    bit          rs_in_txn = 1'b0;
    bit          rs_chk = 1'b0;
    int          rs_idx = 0;
    logic [31:0] rs_dot = '0;
    logic [32*N-1:0] rs_row = '0, rs_col = '0;

    initial begin
        int unsigned mx;
        bus.row_o_ack    = 1'b0;
        bus.column_o_ack = 1'b0;
        bus.result_i_stb = 1'b0;
        bus.result       = '0;
        forever begin
            @(negedge clk);
            if (rs_chk) begin
                if (matrix_c[32*rs_idx +: 32] !== rs_dot) viol++;
                rs_chk = 1'b0;
            end
            bus.row_o_ack    = 1'b0;
            bus.column_o_ack = 1'b0;
            bus.result_i_stb = 1'b0;
            if (!rsp_en) begin
                rs_in_txn = 1'b0;
                rs_txn    = 0;
            end else begin
                mx = (ra > ca) ? ra : ca;
                if (!rs_in_txn && bus.row_o_stb && bus.column_o_stb) begin
                    rs_in_txn = 1'b1;
                    rs_t      = 0;
                    rs_row    = bus.row;
                    rs_col    = bus.column;
                    rs_dot    = '0;
                    for (int k = 0; k < N; k++)
                        rs_dot = rs_dot + rs_row[32*k +: 32] * rs_col[32*k +: 32];
                end
                if (rs_in_txn) begin
                    if ((bus.row_o_stb || bus.column_o_stb) &&
                        (bus.row !== rs_row || bus.column !== rs_col)) viol++;
                    if (bus.row_o_stb !== (rs_t <= ra) || bus.column_o_stb !== (rs_t <= ca)) viol++;
                    if (bus.result_i_ack !== 1'b1 || busy !== 1'b1) viol++;
                    if (rs_t == ra) bus.row_o_ack = 1'b1;
                    if (rs_t == ca) bus.column_o_ack = 1'b1;
                    if (junk && rs_t == 0) begin
                        bus.result_i_stb = 1'b1;
                        bus.result       = 32'hDEAD_BEEF;
                    end
                    if (rs_t == mx + 1 + rd) begin
                        bus.result_i_stb = 1'b1;
                        bus.result       = rs_dot;
                        rs_chk           = 1'b1;
                        rs_idx           = rs_txn;
                        rs_txn++;
                        rs_in_txn        = 1'b0;
                    end
                    rs_t++;
                end
            end
        end
    end

    task automatic rsp_setup(input int unsigned a_dly, c_dly, r_dly, input bit j, input bit en);
        ra = a_dly; ca = c_dly; rd = r_dly; junk = j;
        rsp_en = 1'b0;
        repeat (2) @(negedge clk);
        rsp_en = en;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int v0;
        bit seen;
        rsp_setup(v.ra, v.ca, v.rd, v.junk, 1'b1);
        v0 = viol;
        matrix_a = v.a;
        matrix_b = v.b;
        start = 1'b1;
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, " latency"}, W'(cyc), W'(v.lat));
        check({tag, " busy at done"}, W'(busy), '0);
        check({tag, " matrix_c"}, matrix_c, v.c);
        @(negedge clk);
        check({tag, " done one cycle"}, W'(done), '0);
        check({tag, " handshake violations"}, W'(viol - v0), '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        int   cnt;
        int   v0;
        bit   hit;

        vecs[0] = '{a: pack4(1, 0, 0, 1), b: pack4(1, 2, 3, 4), c: pack4(1, 2, 3, 4),
                    ra: 0, ca: 0, rd: 0,  junk: 1'b0, lat: 14};
        vecs[1] = '{a: pack4(1, 2, 3, 4), b: pack4(5, 6, 7, 8), c: pack4(19, 22, 43, 50),
                    ra: 0, ca: 3, rd: 0,  junk: 1'b1, lat: 26};
        vecs[2] = '{a: pack4(2, 0, 0, 3), b: pack4(1, 1, 1, 1), c: pack4(2, 2, 3, 3),
                    ra: 0, ca: 0, rd: 20, junk: 1'b0, lat: 94};
        vecs[3] = '{a: pack4(0, 1, 1, 0), b: pack4(9, 8, 7, 6), c: pack4(7, 6, 9, 8),
                    ra: 2, ca: 1, rd: 0,  junk: 1'b0, lat: 22};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst row", W'(bus.row), '0);
        check("rst column", W'(bus.column), '0);
        check("rst strobes", W'({bus.row_o_stb, bus.column_o_stb}), '0);
        check("rst result_i_ack", W'(bus.result_i_ack), '0);
        check("rst matrix_c", matrix_c, '0);
        check("rst busy/done/error", W'({busy, done, error}), '0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Restart while busy is ignored; input matrices changing after start have no effect
        rsp_setup(0, 0, 0, 1'b0, 1'b1);
        matrix_a = vecs[0].a;
        matrix_b = vecs[0].b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        matrix_a = vecs[1].a;
        matrix_b = vecs[1].b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check("busy restart done pulses", W'(cnt), W'(1));
        check("busy restart matrix_c", matrix_c, vecs[0].c);

        // Reset mid-run during WAIT_RES of element (1,0)
        rsp_setup(0, 0, 20, 1'b0, 1'b1);
        matrix_a = vecs[1].a;
        matrix_b = vecs[1].b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (rs_in_txn && rs_txn == 2 && rs_t >= 3) hit = 1'b1;
        end
        check("reached element (1,0) wait", W'(hit), W'(1));
        check("partial matrix_c before rst", matrix_c, pack4(19, 22, 0, 0));
        rst = 1'b1;
        rsp_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst row/column", W'({bus.row, bus.column}), '0);
        check("mid rst strobes/ack", W'({bus.row_o_stb, bus.column_o_stb, bus.result_i_ack}), '0);
        check("mid rst matrix_c", matrix_c, '0);
        check("mid rst busy/done/error", W'({busy, done, error}), '0);
        run_vec(vecs[3], "after rst");

        // Reset wins over a simultaneous start
        matrix_a = vecs[0].a;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst over start busy", W'(busy), '0);
        check("rst over start strobes", W'({bus.row_o_stb, bus.column_o_stb}), '0);

        // Responder never acknowledges
        rsp_setup(0, 0, 0, 1'b0, 1'b0);
        matrix_a = vecs[0].a;
        matrix_b = vecs[0].b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("no-ack strobes rise", W'({bus.row_o_stb, bus.column_o_stb}), W'(2'b11));
`ifdef MATMUL_SEQ_TIMEOUT_EN
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check("timeout error before limit", W'(error), '0);
        @(negedge clk);
        if (done === 1'b1) cnt++;
        check("timeout error at limit", W'(error), W'(1));
        check("timeout strobes dropped", W'({bus.row_o_stb, bus.column_o_stb}), '0);
        check("timeout busy", W'(busy), '0);
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check("timeout no done", W'(cnt), '0);
        check("timeout error sticky", W'(error), W'(1));
        run_vec(vecs[0], "after timeout");
        check("error cleared by start", W'(error), '0);
`else
        v0 = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b1 || error !== 1'b0 || done !== 1'b0) v0++;
        end
        check("no-ack waits indefinitely", W'(v0), '0);
        check("no-ack strobes held", W'({bus.row_o_stb, bus.column_o_stb}), W'(2'b11));
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("final rst busy", W'(busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
